// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output between requesters A and B, burst-capped per grant.
// Latency: request seen in IDLE -> grant registered on next edge -> earliest beat accepted 1 cycle after req.
// Backpressure: out_ready low holds grant and burst count; a side only loses the grant via accepted beats or dropping req.
module mux2_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              sel,
  output logic              grant_a,
  output logic              grant_b,
  output logic              ack_a,
  output logic              ack_b
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  // last_q remembers the side most recently served; 1 (B) out of reset so A wins the first tie
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);

  logic [1:0]       state_q, state_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             cap_hit;

  assign grant_a   = (state_q == GNT_A);
  assign grant_b   = (state_q == GNT_B);
  assign out_valid = (grant_a & req_a) | (grant_b & req_b);
  assign out_data  = out_valid ? (sel_q ? data_b : data_a) : '0;
  assign sel       = sel_q;
  assign ack_a     = grant_a & req_a & out_ready;
  assign ack_b     = grant_b & req_b & out_ready;
  assign accept    = out_valid & out_ready;
  assign cap_hit   = (cnt_q == CNT_CAP);

  // Next-state: grant selection, burst counting and handover between sides
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_a && (!req_b || last_q == SIDE_B)) begin
          state_d = GNT_A;
          sel_d   = SIDE_A;
          cnt_d   = '0;
        end else if (req_b) begin
          state_d = GNT_B;
          sel_d   = SIDE_B;
          cnt_d   = '0;
        end
      end
      GNT_A: begin
        if (!req_a || (accept && cap_hit && req_b)) begin
          last_d = SIDE_A;
          cnt_d  = '0;
          if (req_b) begin
            state_d = GNT_B;
            sel_d   = SIDE_B;
          end else begin
            state_d = IDLE;
          end
        end else if (accept && !cap_hit) begin
          // at the cap with nobody waiting the count saturates and A keeps going
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GNT_B: begin
        if (!req_b || (accept && cap_hit && req_a)) begin
          last_d = SIDE_B;
          cnt_d  = '0;
          if (req_a) begin
            state_d = GNT_A;
            sel_d   = SIDE_A;
          end else begin
            state_d = IDLE;
          end
        end else if (accept && !cap_hit) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SIDE_A;
        cnt_d   = '0;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= SIDE_A;
      last_q  <= SIDE_B;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
module tb_mux2_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_a, req_b, out_ready;
  logic [DW-1:0] data_a, data_b;
  logic          out_valid, sel, grant_a, grant_b, ack_a, ack_b;
  logic [DW-1:0] out_data;

  mux2_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .sel       (sel),
    .grant_a   (grant_a),
    .grant_b   (grant_b),
    .ack_a     (ack_a),
    .ack_b     (ack_b)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner 0=nobody 1=A 2=B, beats = beats accepted in the current grant
  int   m_owner, m_last, m_beats;
  logic m_sel, m_acka, m_ackb;

  // Last observed DUT values, for directed checks
  logic          obs_valid, obs_acka, obs_ackb, obs_ga, obs_gb, obs_sel;
  logic [DW-1:0] obs_data;

  task automatic model_reset();
    m_owner = 0;
    m_last  = 2;
    m_beats = 0;
    m_sel   = 1'b0;
  endtask

  // One clock: check outputs at the negedge against the model, then advance the model
  task automatic step();
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic          mine, theirs;
    int            other;
    @(negedge clk);
    exp_valid = (m_owner == 1 && req_a) || (m_owner == 2 && req_b);
    m_acka    = (m_owner == 1) && req_a && out_ready;
    m_ackb    = (m_owner == 2) && req_b && out_ready;
    exp_data  = !exp_valid ? '0 : (m_owner == 2 ? data_b : data_a);
    obs_valid = out_valid; obs_data = out_data; obs_acka = ack_a; obs_ackb = ack_b;
    obs_ga = grant_a; obs_gb = grant_b; obs_sel = sel;
    chk("out_valid", out_valid, exp_valid);
    chk("out_data",  out_data,  exp_data);
    chk("sel",       sel,       m_sel);
    chk("grant_a",   grant_a,   m_owner == 1);
    chk("grant_b",   grant_b,   m_owner == 2);
    chk("ack_a",     ack_a,     m_acka);
    chk("ack_b",     ack_b,     m_ackb);
    if (m_owner == 0) begin
      if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
      else if (req_a)     m_owner = 1;
      else if (req_b)     m_owner = 2;
      m_beats = 0;
    end else begin
      mine   = (m_owner == 1) ? req_a : req_b;
      theirs = (m_owner == 1) ? req_b : req_a;
      other  = 3 - m_owner;
      if (!mine) begin
        m_last  = m_owner;
        m_owner = theirs ? other : 0;
        m_beats = 0;
      end else if (m_acka || m_ackb) begin
        if (m_beats + 1 >= MB && theirs) begin
          m_last  = m_owner;
          m_owner = other;
          m_beats = 0;
        end else begin
          m_beats = (m_beats + 1 > MB - 1) ? MB - 1 : m_beats + 1;
        end
      end
    end
    if (m_owner == 1) m_sel = 1'b0;
    else if (m_owner == 2) m_sel = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ga"},   grant_a,   1'b0);
    chk({tag, "_gb"},   grant_b,   1'b0);
    chk({tag, "_vld"},  out_valid, 1'b0);
    chk({tag, "_sel"},  sel,       1'b0);
    chk({tag, "_dat"},  out_data,  8'h00);
    chk({tag, "_acka"}, ack_a,     1'b0);
    chk({tag, "_ackb"}, ack_b,     1'b0);
  endtask

  // Reset with both sides requesting; called at posedge+1
  task automatic do_reset();
    rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; out_ready = 1'b1;
    data_a = 8'hA1; data_b = 8'hB1;
    #1;
    chk_all_zero("reset");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Random requester behaviour; pdrop>0 lets a waiting requester occasionally withdraw
  task automatic refresh(input int pdrop);
    if (m_acka) begin
      req_a = ($urandom_range(0, 3) != 0); data_a = 8'($urandom);
    end else if (!req_a) begin
      req_a = ($urandom_range(0, 2) == 0); data_a = 8'($urandom);
    end else if (pdrop > 0 && $urandom_range(0, pdrop - 1) == 0) begin
      req_a = 1'b0;
    end
    if (m_ackb) begin
      req_b = ($urandom_range(0, 3) != 0); data_b = 8'($urandom);
    end else if (!req_b) begin
      req_b = ($urandom_range(0, 2) == 0); data_b = 8'($urandom);
    end else if (pdrop > 0 && $urandom_range(0, pdrop - 1) == 0) begin
      req_b = 1'b0;
    end
    out_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    logic [15:0] bpat;
    int          nack, nheld;
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    data_a = '0; data_b = '0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single A request
    req_b = 1'b0; req_a = 1'b1; data_a = 8'h5A;
    step();
    chk("single_idle_vld", obs_valid, 1'b0);
    step();
    chk("single_ga",   obs_ga,    1'b1);
    chk("single_vld",  obs_valid, 1'b1);
    chk("single_dat",  obs_data,  8'h5A);
    chk("single_acka", obs_acka,  1'b1);
    req_a = 1'b0;
    step();
    step();

    // Tie after reset goes to A, then capped bursts alternate with no gap
    do_reset();
    step();
    bpat = '0;
    nack = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 0) begin
        chk("tie_ga",  obs_ga,  1'b1);
        chk("tie_sel", obs_sel, 1'b0);
      end
      bpat[i] = obs_ackb;
      if (obs_acka || obs_ackb) nack++;
      if (m_acka) data_a = 8'($urandom);
      if (m_ackb) data_b = 8'($urandom);
    end
    chk("burst_pattern", bpat, 16'hF0F0);
    chk("burst_no_gap",  nack, 16);

    // Stall mid-grant: one A beat, then 10 cycles without ready
    step();
    chk("stall_pre_acka", obs_acka, 1'b1);
    out_ready = 1'b0;
    nack = 0;
    nheld = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_acka || obs_ackb) nack++;
      if (obs_ga) nheld++;
    end
    chk("stall_no_ack", nack, 0);
    chk("stall_held",   nheld, 10);
    out_ready = 1'b1;
    nack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs_acka) nack++;
    end
    chk("stall_resume_a", nack, 3);
    step();
    chk("stall_then_b", obs_ackb, 1'b1);

    // Async reset mid-burst after two A beats
    do_reset();
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    chk("midrst_tie_ga", obs_ga, 1'b1);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      refresh(20);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
